// File: rtl/param_datapath_if.sv
// ============================================================================
// Module   : param_datapath_if
// Brief    : Op-issue, register-write and result bus of param_datapath.
//            master = controller / external I/O side, slave = datapath side.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface param_datapath_if #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 16,
  parameter int IN_W   = 64
);
  localparam int AW  = $clog2(NREGS);
  localparam int NSL = IN_W / DATA_W;
  localparam int SW  = (NSL > 1) ? $clog2(NSL) : 1;

  // register write path
  logic [IN_W-1:0]   InPort;
  logic [SW-1:0]     Sel;
  logic              Wen;
  logic [AW-1:0]     WA;

  // op issue handshake
  logic              OpValid;
  logic              OpReady;
  logic [2:0]        Op;
  logic [AW-1:0]     RAA;
  logic [AW-1:0]     RAB;

  // results and status
  logic [DATA_W-1:0] OutPort;
  logic              OutValid;
  logic              Flag;
  logic              Busy;
  logic              Err;

  modport master (
    output InPort, Sel, Wen, WA, OpValid, Op, RAA, RAB,
    input  OpReady, OutPort, OutValid, Flag, Busy, Err
  );

  modport slave (
    input  InPort, Sel, Wen, WA, OpValid, Op, RAA, RAB,
    output OpReady, OutPort, OutValid, Flag, Busy, Err
  );
endinterface

`default_nettype wire

// File: rtl/param_datapath.sv
// ============================================================================
// Module   : param_datapath
// Brief    : Parametrised datapath: register file loaded from InPort slices,
//            ALU issued via valid/ready, output register Y (OutPort), sticky
//            EQ Flag. Single-cycle ops complete at the accept edge.
// Config   : DP_MUL_EN - when defined, opcode 111 is a DATA_W-cycle shift-add
//            multiplier that stalls issue; when undefined, opcode 111 is
//            illegal and pulses Err.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_datapath #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 16,
  parameter int IN_W   = 64
) (
  input wire              clk,
  input wire              rst_n,
  param_datapath_if.slave bus
);

  localparam int c_NSL  = IN_W / DATA_W;
  localparam int c_SW   = (c_NSL > 1) ? $clog2(c_NSL) : 1;
  localparam int c_NSEL = 2 ** c_SW;

  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_SHR = 3'b001;
  localparam logic [2:0] c_OP_EQ  = 3'b010;
  localparam logic [2:0] c_OP_AND = 3'b011;
  localparam logic [2:0] c_OP_MOV = 3'b100;
  localparam logic [2:0] c_OP_SUB = 3'b101;
  localparam logic [2:0] c_OP_NOP = 3'b110;
  localparam logic [2:0] c_OP_MUL = 3'b111;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [DATA_W-1:0] w_slices [c_NSEL];
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic              w_accept;
  logic              w_busy;

  logic [DATA_W-1:0] r_y;
  logic              r_out_valid;
  logic              r_flag;
  logic              r_err;

  // --------------------------------------------------------------------------
  // InPort slicing. Select codes beyond the last real slice map to zero so an
  // out-of-range Sel writes 0 without needing a magnitude comparator.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < c_NSEL; gi++) begin : g_slice
    if (gi < c_NSL) begin : g_live
      assign w_slices[gi] = bus.InPort[gi*DATA_W +: DATA_W];
    end else begin : g_zero
      assign w_slices[gi] = '0;
    end
  end

  assign w_wdata = w_slices[bus.Sel];

  // Register file write port; independent of the op handshake and of Busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (bus.Wen) begin
      r_regs[bus.WA] <= w_wdata;
    end
  end

  // Operands read the pre-edge contents, so a same-cycle write is not seen.
  assign w_a      = r_regs[bus.RAA];
  assign w_b      = r_regs[bus.RAB];
  assign w_accept = bus.OpValid & ~w_busy;

`ifdef DP_MUL_EN
  // --------------------------------------------------------------------------
  // Shift-add multiplier: one multiplier bit per cycle, low DATA_W bits kept.
  // --------------------------------------------------------------------------
  localparam int c_CW = $clog2(DATA_W);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_mul_a;
  logic [DATA_W-1:0] r_mul_b;
  logic [DATA_W-1:0] r_mul_acc;
  logic [c_CW-1:0]   r_mul_cnt;
  logic              w_mul_start;
  logic              w_mul_done;
  logic [DATA_W-1:0] w_mul_sum;

  assign w_mul_start = w_accept && (bus.Op == c_OP_MUL);
  assign w_mul_done  = (r_state == S_MUL) && (r_mul_cnt == c_CW'(DATA_W - 1));
  // Partial sum including the current multiplier bit; on the last bit this is
  // the final product.
  assign w_mul_sum   = r_mul_acc + (r_mul_b[0] ? r_mul_a : '0);
  assign w_busy      = (r_state == S_MUL);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state: start on MUL accept, return when the last bit is done
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_mul_start) w_state_nxt = S_MUL;
      S_MUL:   if (w_mul_done)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Multiplier operand latch and shift-add iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mul_a   <= '0;
      r_mul_b   <= '0;
      r_mul_acc <= '0;
      r_mul_cnt <= '0;
    end else if (w_mul_start) begin
      r_mul_a   <= w_a;
      r_mul_b   <= w_b;
      r_mul_acc <= '0;
      r_mul_cnt <= '0;
    end else if (r_state == S_MUL) begin
      r_mul_acc <= w_mul_sum;
      r_mul_a   <= r_mul_a << 1;
      r_mul_b   <= r_mul_b >> 1;
      r_mul_cnt <= r_mul_cnt + c_CW'(1);
    end
  end
`else
  // No multiplier: issue never stalls.
  assign w_busy = 1'b0;
`endif

  // ALU result, flag and one-cycle status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y         <= '0;
      r_out_valid <= 1'b0;
      r_flag      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
      if (w_accept) begin
        case (bus.Op)
          c_OP_ADD: begin
            r_y         <= w_a + w_b;
            r_out_valid <= 1'b1;
          end
          c_OP_SHR: begin
            r_y         <= w_a >> 1;
            r_out_valid <= 1'b1;
          end
          c_OP_EQ: begin
            r_flag <= (w_a == w_b);
          end
          c_OP_AND: begin
            r_y         <= w_a & w_b;
            r_out_valid <= 1'b1;
          end
          c_OP_MOV: begin
            r_y         <= w_a;
            r_out_valid <= 1'b1;
          end
          c_OP_SUB: begin
            r_y         <= w_a - w_b;
            r_out_valid <= 1'b1;
          end
          c_OP_NOP: begin
          end
          c_OP_MUL: begin
`ifndef DP_MUL_EN
            r_err <= 1'b1;
`endif
          end
          default: begin
          end
        endcase
      end
`ifdef DP_MUL_EN
      // The multiplier can only finish while issue is stalled, so it never
      // collides with a single-cycle result.
      if (w_mul_done) begin
        r_y         <= w_mul_sum;
        r_out_valid <= 1'b1;
      end
`endif
    end
  end

  assign bus.OutPort  = r_y;
  assign bus.OutValid = r_out_valid;
  assign bus.Flag     = r_flag;
  assign bus.Err      = r_err;
  assign bus.Busy     = w_busy;
  assign bus.OpReady  = ~w_busy;

endmodule

`default_nettype wire

// File: tb/tb_param_datapath.sv
// ============================================================================
// Module   : tb_param_datapath
// Brief    : Self-checking bench for param_datapath (DATA_W=8, NREGS=16,
//            IN_W=64) with directed and random ops against an arithmetic
//            reference model. Covers DP_MUL_EN defined and undefined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_datapath;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [7:0] m_regs [16];
  logic [7:0] m_y;
  logic       m_flag;

  param_datapath_if #(.DATA_W(8), .NREGS(16), .IN_W(64)) bus ();

  param_datapath #(.DATA_W(8), .NREGS(16), .IN_W(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.Wen     = 1'b0;
    bus.WA      = '0;
    bus.Sel     = '0;
    bus.InPort  = '0;
    bus.OpValid = 1'b0;
    bus.Op      = 3'd6;
    bus.RAA     = '0;
    bus.RAB     = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_y    = 8'h00;
    m_flag = 1'b0;
  endtask

  // Reference: applies one accepted op, returns whether OutValid is expected.
  function automatic bit model_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int prod;
    case (op)
      3'd0: begin m_y = a + b;  return 1'b1; end
      3'd1: begin m_y = a / 2;  return 1'b1; end
      3'd2: begin m_flag = (a == b); return 1'b0; end
      3'd3: begin m_y = a & b;  return 1'b1; end
      3'd4: begin m_y = a;      return 1'b1; end
      3'd5: begin m_y = a - b;  return 1'b1; end
      3'd6: return 1'b0;
      default: begin
`ifdef DP_MUL_EN
        prod = int'(a) * int'(b);
        m_y  = prod[7:0];
        return 1'b1;
`else
        return 1'b0;
`endif
      end
    endcase
  endfunction

  task automatic write_reg(input logic [3:0] wa, input logic [2:0] sel, input logic [7:0] d);
    logic [63:0] w;
    w = {$urandom, $urandom};
    w[sel*8 +: 8] = d;
    bus.InPort = w;
    bus.Sel    = sel;
    bus.WA     = wa;
    bus.Wen    = 1'b1;
    step();
    bus.Wen    = 1'b0;
    m_regs[wa] = d;
  endtask

  task automatic issue(input logic [2:0] op, input logic [3:0] raa, input logic [3:0] rab);
    bus.Op      = op;
    bus.RAA     = raa;
    bus.RAB     = rab;
    bus.OpValid = 1'b1;
    step();
    bus.OpValid = 1'b0;
  endtask

  task automatic test_reset();
    bit v;
    model_clear();
    drive_idle();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (bus.OutPort !== 8'h00) begin errors++; $display("FAIL rst_outport: got %h exp 00", bus.OutPort); end
    checks++; if (bus.OutValid !== 1'b0) begin errors++; $display("FAIL rst_outvalid: got %b exp 0", bus.OutValid); end
    checks++; if (bus.Flag !== 1'b0) begin errors++; $display("FAIL rst_flag: got %b exp 0", bus.Flag); end
    checks++; if (bus.OpReady !== 1'b1 || bus.Busy !== 1'b0 || bus.Err !== 1'b0)
      begin errors++; $display("FAIL rst_status: got rdy=%b busy=%b err=%b exp 1/0/0", bus.OpReady, bus.Busy, bus.Err); end
    rst_n = 1'b1;
    // build up some state, then reset in the middle of traffic
    write_reg(4'd5, 3'($urandom_range(0, 7)), 8'hA5);
    issue(3'd4, 4'd5, 4'd0);
    v = model_op(3'd4, m_regs[5], m_regs[0]);
    issue(3'd2, 4'd5, 4'd5);
    v = model_op(3'd2, m_regs[5], m_regs[5]);
    bus.Op = 3'd0; bus.RAA = 4'd5; bus.RAB = 4'd5; bus.OpValid = 1'b1;
    bus.Wen = 1'b1; bus.WA = 4'd6; bus.InPort = {$urandom, $urandom};
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.OutPort !== 8'h00 || bus.Flag !== 1'b0 || bus.OutValid !== 1'b0)
      begin errors++; $display("FAIL midrst_out: got y=%h flag=%b ov=%b exp 00/0/0", bus.OutPort, bus.Flag, bus.OutValid); end
    checks++; if (bus.OpReady !== 1'b1 || bus.Busy !== 1'b0 || bus.Err !== 1'b0)
      begin errors++; $display("FAIL midrst_status: got rdy=%b busy=%b err=%b exp 1/0/0", bus.OpReady, bus.Busy, bus.Err); end
    drive_idle();
    model_clear();
    step();
    rst_n = 1'b1;
    issue(3'd4, 4'd5, 4'd0);
    v = model_op(3'd4, m_regs[5], m_regs[0]);
    checks++; if (bus.OutPort !== m_y || bus.OutValid !== v)
      begin errors++; $display("FAIL midrst_regs: got y=%h ov=%b exp %h/%b", bus.OutPort, bus.OutValid, m_y, v); end
  endtask

  task automatic test_directed();
    bit v;
    write_reg(4'd1, 3'd0, 8'h05);
    write_reg(4'd2, 3'd7, 8'hFB);
    issue(3'd0, 4'd1, 4'd2);
    v = model_op(3'd0, m_regs[1], m_regs[2]);
    checks++; if (bus.OutPort !== 8'h00 || bus.OutValid !== 1'b1 || bus.Flag !== 1'b0)
      begin errors++; $display("FAIL add_wrap: got y=%h ov=%b flag=%b exp 00/1/0", bus.OutPort, bus.OutValid, bus.Flag); end
    step();
    checks++; if (bus.OutValid !== 1'b0) begin errors++; $display("FAIL ov_pulse: got %b exp 0", bus.OutValid); end
    issue(3'd2, 4'd1, 4'd1);
    v = model_op(3'd2, m_regs[1], m_regs[1]);
    checks++; if (bus.Flag !== 1'b1 || bus.OutPort !== 8'h00 || bus.OutValid !== 1'b0)
      begin errors++; $display("FAIL eq_true: got flag=%b y=%h ov=%b exp 1/00/0", bus.Flag, bus.OutPort, bus.OutValid); end
    issue(3'd5, 4'd1, 4'd2);
    v = model_op(3'd5, m_regs[1], m_regs[2]);
    checks++; if (bus.OutPort !== 8'h0A || bus.OutValid !== 1'b1 || bus.Flag !== 1'b1)
      begin errors++; $display("FAIL sub: got y=%h ov=%b flag=%b exp 0a/1/1", bus.OutPort, bus.OutValid, bus.Flag); end
    // same-cycle write to the operand register is not forwarded
    bus.InPort = {$urandom, $urandom};
    bus.InPort[3*8 +: 8] = 8'h77;
    bus.Sel = 3'd3; bus.WA = 4'd3; bus.Wen = 1'b1;
    issue(3'd4, 4'd3, 4'd0);
    bus.Wen = 1'b0;
    v = model_op(3'd4, m_regs[3], m_regs[0]);
    m_regs[3] = 8'h77;
    checks++; if (bus.OutPort !== 8'h00) begin errors++; $display("FAIL no_fwd: got %h exp 00", bus.OutPort); end
    issue(3'd4, 4'd3, 4'd0);
    v = model_op(3'd4, m_regs[3], m_regs[0]);
    checks++; if (bus.OutPort !== 8'h77) begin errors++; $display("FAIL mov_after_wr: got %h exp 77", bus.OutPort); end
    // NOP changes nothing
    issue(3'd6, 4'd1, 4'd2);
    checks++; if (bus.OutPort !== 8'h77 || bus.OutValid !== 1'b0 || bus.Flag !== 1'b1)
      begin errors++; $display("FAIL nop: got y=%h ov=%b flag=%b exp 77/0/1", bus.OutPort, bus.OutValid, bus.Flag); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] op;
    logic [3:0] ra, rb;
    bit v;
    bus.OpValid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      op = 3'($urandom_range(0, 5));
      if (op == 3'd2) op = 3'd0;
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      bus.Op = op; bus.RAA = ra; bus.RAB = rb;
      v = model_op(op, m_regs[ra], m_regs[rb]);
      step();
      checks++; if (bus.OutPort !== m_y || bus.OutValid !== v)
        begin errors++; $display("FAIL b2b[%0d]: got y=%h ov=%b exp %h/%b", i, bus.OutPort, bus.OutValid, m_y, v); end
    end
    bus.OpValid = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic [63:0] inw;
    logic [3:0]  wa, ra, rb;
    logic [2:0]  sel, op;
    logic [7:0]  a, b;
    bit          wen, ov, v;
    for (int i = 0; i < 300; i++) begin
      wen = 1'($urandom_range(0, 1));
      wa  = 4'($urandom_range(0, 15));
      sel = 3'($urandom_range(0, 7));
      inw = {$urandom, $urandom};
      ov  = ($urandom_range(0, 3) != 0);
      op  = 3'($urandom_range(0, 6));
      ra  = 4'($urandom_range(0, 15));
      rb  = 4'($urandom_range(0, 15));
      bus.InPort = inw; bus.Sel = sel; bus.WA = wa; bus.Wen = wen;
      bus.OpValid = ov; bus.Op = ov ? op : 3'($urandom_range(0, 7)); bus.RAA = ra; bus.RAB = rb;
      a = m_regs[ra];
      b = m_regs[rb];
      v = ov ? model_op(op, a, b) : 1'b0;
      if (wen) m_regs[wa] = inw[sel*8 +: 8];
      step();
      checks++; if (bus.OutPort !== m_y || bus.OutValid !== v || bus.Flag !== m_flag || bus.Err !== 1'b0 || bus.OpReady !== 1'b1) begin
        errors++;
        $display("FAIL rand[%0d] op=%0d: got y=%h ov=%b flag=%b err=%b rdy=%b exp %h/%b/%b/0/1",
                 i, op, bus.OutPort, bus.OutValid, bus.Flag, bus.Err, bus.OpReady, m_y, v, m_flag);
      end
    end
    drive_idle();
    step();
  endtask

`ifdef DP_MUL_EN
  task automatic test_mul();
    int  low;
    bit  done;
    bit  v;
    logic [7:0] a, b;
    int  lat;
    write_reg(4'd1, 3'd2, 8'h0C);
    write_reg(4'd2, 3'd5, 8'h0B);
    issue(3'd7, 4'd1, 4'd2);
    v = model_op(3'd7, m_regs[1], m_regs[2]);
    // ADD request held while the multiplier runs
    bus.Op = 3'd0; bus.RAA = 4'd1; bus.RAB = 4'd2; bus.OpValid = 1'b1;
    low  = 0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (bus.OpReady === 1'b1) begin
        done = 1'b1;
      end else begin
        low++;
        checks++; if (bus.Busy !== 1'b1 || bus.OutValid !== 1'b0)
          begin errors++; $display("FAIL mul_busy[%0d]: got busy=%b ov=%b exp 1/0", c, bus.Busy, bus.OutValid); end
        if (c == 2) begin
          bus.InPort = {$urandom, $urandom}; bus.InPort[7:0] = 8'h33;
          bus.Sel = 3'd0; bus.WA = 4'd1; bus.Wen = 1'b1;
          m_regs[1] = 8'h33;
        end else begin
          bus.Wen = 1'b0;
        end
        step();
      end
    end
    bus.Wen = 1'b0;
    checks++; if (!done || low != 8) begin errors++; $display("FAIL mul_stall: got %0d low cycles (done=%b) exp 8", low, done); end
    checks++; if (bus.OutPort !== 8'h84 || bus.OutValid !== 1'b1)
      begin errors++; $display("FAIL mul_result: got y=%h ov=%b exp 84/1", bus.OutPort, bus.OutValid); end
    step();
    bus.OpValid = 1'b0;
    v = model_op(3'd0, m_regs[1], m_regs[2]);
    checks++; if (bus.OutPort !== 8'h3E || bus.OutValid !== 1'b1)
      begin errors++; $display("FAIL mul_stalled_add: got y=%h ov=%b exp 3e/1", bus.OutPort, bus.OutValid); end
    // random and boundary operands
    for (int t = 0; t < 5; t++) begin
      a = (t == 0) ? 8'hFF : 8'($urandom);
      b = (t == 0) ? 8'hFF : 8'($urandom);
      write_reg(4'd8, 3'($urandom_range(0, 7)), a);
      write_reg(4'd9, 3'($urandom_range(0, 7)), b);
      issue(3'd7, 4'd8, 4'd9);
      v = model_op(3'd7, a, b);
      lat = 0;
      while (bus.OutValid !== 1'b1 && lat < 20) begin
        step();
        lat++;
      end
      checks++; if (lat != 8 || bus.OutPort !== m_y)
        begin errors++; $display("FAIL mul_rand[%0d]: got y=%h lat=%0d exp %h/8", t, bus.OutPort, lat, m_y); end
    end
    step();
  endtask

  task automatic test_mul_reset();
    bit seen;
    write_reg(4'd1, 3'd1, 8'h5A);
    issue(3'd7, 4'd1, 4'd1);
    step();
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.OutPort !== 8'h00 || bus.OutValid !== 1'b0 || bus.Flag !== 1'b0 || bus.Err !== 1'b0)
      begin errors++; $display("FAIL mulrst_out: got y=%h ov=%b flag=%b err=%b exp 00/0/0/0", bus.OutPort, bus.OutValid, bus.Flag, bus.Err); end
    checks++; if (bus.OpReady !== 1'b1 || bus.Busy !== 1'b0)
      begin errors++; $display("FAIL mulrst_status: got rdy=%b busy=%b exp 1/0", bus.OpReady, bus.Busy); end
    model_clear();
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (bus.OutValid !== 1'b0 || bus.OpReady !== 1'b1) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL mulrst_late: got late OutValid or stall, exp none"); end
  endtask
`else
  task automatic test_illegal();
    bit v;
    write_reg(4'd4, 3'd6, 8'h3C);
    issue(3'd4, 4'd4, 4'd0);
    v = model_op(3'd4, m_regs[4], m_regs[0]);
    issue(3'd7, 4'd4, 4'd4);
    checks++; if (bus.Err !== 1'b1 || bus.OutPort !== m_y || bus.OutValid !== 1'b0 || bus.Flag !== m_flag)
      begin errors++; $display("FAIL illegal: got err=%b y=%h ov=%b flag=%b exp 1/%h/0/%b", bus.Err, bus.OutPort, bus.OutValid, bus.Flag, m_y, m_flag); end
    checks++; if (bus.OpReady !== 1'b1 || bus.Busy !== 1'b0)
      begin errors++; $display("FAIL illegal_rdy: got rdy=%b busy=%b exp 1/0", bus.OpReady, bus.Busy); end
    step();
    checks++; if (bus.Err !== 1'b0) begin errors++; $display("FAIL err_pulse: got %b exp 0", bus.Err); end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive_idle();
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
`ifdef DP_MUL_EN
    test_mul();
    test_mul_reset();
`else
    test_illegal();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
